// File: rtl/instruction_prefetch_pkg.sv
// Shared types and address helper for the instruction prefetch unit.
// Also used by the load/store unit for physical address generation.
package instruction_prefetch_pkg;

    localparam int unsigned SEG_W  = 16;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PHYS_W = 20;
    localparam int unsigned ADDR_W = 19;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PUSH_LO = 2'd2,
        PUSH_HI = 2'd3
    } prefetch_state_t;

    // Segmented physical address: cs*16 + ip, wrapping at 1 MiB.
    function automatic logic [PHYS_W-1:0] phys_addr(input logic [SEG_W-1:0] cs,
                                                    input logic [SEG_W-1:0] ip);
        return {cs, 4'b0000} + {4'b0000, ip};
    endfunction

endpackage

// File: rtl/instruction_prefetch_if.sv
// Bundle of branch, FIFO and memory signals around the prefetch unit.
//  master: the prefetcher (drives FIFO pushes/flush and memory requests)
//  slave : the environment (core branch request, FIFO status, memory response)
interface instruction_prefetch_if;
    import instruction_prefetch_pkg::*;

    logic                load_new_ip;
    logic [SEG_W-1:0]    new_cs;
    logic [SEG_W-1:0]    new_ip;
    logic                fifo_wr_en;
    logic [BYTE_W-1:0]   fifo_wr_data;
    logic                fifo_full;
    logic                fifo_reset;
    logic                mem_access;
    logic [ADDR_W-1:0]   mem_address;
    logic                mem_ack;
    logic [WORD_W-1:0]   mem_data;

    modport master (
        input  load_new_ip, new_cs, new_ip, fifo_full, mem_ack, mem_data,
        output fifo_wr_en, fifo_wr_data, fifo_reset, mem_access, mem_address
    );

    modport slave (
        output load_new_ip, new_cs, new_ip, fifo_full, mem_ack, mem_data,
        input  fifo_wr_en, fifo_wr_data, fifo_reset, mem_access, mem_address
    );

endinterface

// File: rtl/instruction_prefetch.sv
// Instruction prefetch: reads 16-bit words at CS:IP and pushes them byte by
// byte into the instruction FIFO; an odd IP skips the even byte. A branch
// (load_new_ip) flushes the FIFO and restarts fetching at the new CS:IP.
// Ports:
//  clk, reset  single clock, asynchronous active-high reset
//  bus         instruction_prefetch_if.master (branch, FIFO, memory signals)
module instruction_prefetch
    import instruction_prefetch_pkg::*;
#(
    parameter logic [15:0] RESET_CS = 16'hffff,
    parameter logic [15:0] RESET_IP = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset,
    instruction_prefetch_if.master bus
);

    prefetch_state_t     state, state_next;
    logic [SEG_W-1:0]    cs, cs_next;
    logic [SEG_W-1:0]    ip, ip_next;
    logic [SEG_W-1:0]    pend_cs, pend_cs_next;
    logic [SEG_W-1:0]    pend_ip, pend_ip_next;
    logic                abort, abort_next;
    logic [WORD_W-1:0]   word, word_next;
    logic                push_c;
    logic [PHYS_W-1:0]   phys;
    logic                unused_phys_lsb;

    // A byte leaves only from a push state with FIFO room and no flush.
    assign push_c = ((state == PUSH_LO) || (state == PUSH_HI)) &&
                    !bus.fifo_full && !bus.load_new_ip;

    // Word address straight from CS:IP; bit 0 selects the byte, not the word.
    assign phys            = phys_addr(cs, ip);
    assign bus.mem_address = phys[PHYS_W-1:1];
    assign unused_phys_lsb = phys[0];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cs      <= RESET_CS;
            ip      <= RESET_IP;
            pend_cs <= RESET_CS;
            pend_ip <= RESET_IP;
            abort   <= 1'b0;
            word    <= '0;
        end else begin
            state   <= state_next;
            cs      <= cs_next;
            ip      <= ip_next;
            pend_cs <= pend_cs_next;
            pend_ip <= pend_ip_next;
            abort   <= abort_next;
            word    <= word_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next   = state;
        cs_next      = cs;
        ip_next      = ip;
        pend_cs_next = pend_cs;
        pend_ip_next = pend_ip;
        abort_next   = abort;
        word_next    = word;
        case (state)
            IDLE: begin
                if (bus.load_new_ip) begin
                    cs_next = bus.new_cs;
                    ip_next = bus.new_ip;
                end else if (!bus.fifo_full) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (bus.mem_ack) begin
                    abort_next = 1'b0;
                    if (bus.load_new_ip) begin
                        cs_next    = bus.new_cs;
                        ip_next    = bus.new_ip;
                        state_next = IDLE;
                    end else if (abort) begin
                        // Aborted fetch: drop the word, commit the staged target.
                        cs_next    = pend_cs;
                        ip_next    = pend_ip;
                        state_next = IDLE;
                    end else begin
                        word_next  = bus.mem_data;
                        state_next = ip[0] ? PUSH_HI : PUSH_LO;
                    end
                end else if (bus.load_new_ip) begin
                    // Address must stay stable until ack, so stage the target.
                    abort_next   = 1'b1;
                    pend_cs_next = bus.new_cs;
                    pend_ip_next = bus.new_ip;
                end
            end
            PUSH_LO: begin
                if (bus.load_new_ip) begin
                    cs_next    = bus.new_cs;
                    ip_next    = bus.new_ip;
                    state_next = IDLE;
                end else if (push_c) begin
                    ip_next    = ip + 16'd1;
                    state_next = PUSH_HI;
                end
            end
            PUSH_HI: begin
                if (bus.load_new_ip) begin
                    cs_next    = bus.new_cs;
                    ip_next    = bus.new_ip;
                    state_next = IDLE;
                end else if (push_c) begin
                    ip_next    = ip + 16'd1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        bus.fifo_wr_en   = push_c;
        bus.fifo_wr_data = (state == PUSH_HI) ? word[15:8] : word[7:0];
        bus.mem_access   = (state == FETCH);
        bus.fifo_reset   = bus.load_new_ip & ~reset;
    end

endmodule

// File: tb/tb_instruction_prefetch.sv
// Directed bench for instruction_prefetch: stimulus queues expected bytes,
// a monitor pops and compares every FIFO push.
module tb_instruction_prefetch;

    logic clk;
    logic reset;
    instruction_prefetch_if bus();

    instruction_prefetch dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pop and compare every byte the DUT pushes.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.fifo_wr_en === 1'b1) begin
                check("push_while_full", 32'(bus.fifo_full), 32'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_push: got %h expected none", bus.fifo_wr_data);
                end else begin
                    check("push_data", 32'(bus.fifo_wr_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_bus(input bit exp_acc, input logic [18:0] addr, input string name);
        @(negedge clk);
        check({name, "_access"}, 32'(bus.mem_access), 32'(exp_acc));
        if (exp_acc) check({name, "_addr"}, 32'(bus.mem_address), 32'(addr));
    endtask

    task automatic wait_fetch(input logic [18:0] addr, input string name);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.mem_access === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got no mem_access expected request", name);
        end else begin
            check({name, "_addr"}, 32'(bus.mem_address), 32'(addr));
        end
    endtask

    task automatic ack_word(input logic [15:0] data);
        @(posedge clk); #1;
        bus.mem_ack  = 1'b1;
        bus.mem_data = data;
        @(posedge clk); #1;
        bus.mem_ack  = 1'b0;
    endtask

    task automatic pulse_load(input logic [15:0] cs, input logic [15:0] ip,
                              input bit with_ack, input string name);
        @(posedge clk); #1;
        bus.load_new_ip = 1'b1;
        bus.new_cs      = cs;
        bus.new_ip      = ip;
        if (with_ack) begin
            bus.mem_ack  = 1'b1;
            bus.mem_data = 16'hdead;
        end
        @(negedge clk);
        check({name, "_fifo_reset"}, 32'(bus.fifo_reset), 32'd1);
        check({name, "_no_push"}, 32'(bus.fifo_wr_en), 32'd0);
        @(posedge clk); #1;
        bus.load_new_ip = 1'b0;
        bus.mem_ack     = 1'b0;
        @(negedge clk);
        check({name, "_fifo_reset_off"}, 32'(bus.fifo_reset), 32'd0);
    endtask

    // n pushes on consecutive cycles, then a quiet cycle.
    task automatic expect_pushes(input int n, input string name);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check({name, "_push"}, 32'(bus.fifo_wr_en), 32'd1);
        end
        @(negedge clk);
        check({name, "_idle"}, 32'(bus.fifo_wr_en), 32'd0);
    endtask

    initial begin
        reset           = 1'b1;
        bus.load_new_ip = 1'b0;
        bus.new_cs      = '0;
        bus.new_ip      = '0;
        bus.fifo_full   = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.mem_data    = '0;

        // 1: reset, release, first fetch at ffff:0000.
        repeat (3) begin
            @(negedge clk);
            check("rst_access", 32'(bus.mem_access), 32'd0);
            check("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
            check("rst_fifo_reset", 32'(bus.fifo_reset), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        check_bus(1'b0, 19'h0, "t1_idle");
        check_bus(1'b1, 19'h7fff8, "t1_fetch");
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        ack_word(16'h2211);
        expect_pushes(2, "t1");
        wait_fetch(19'h7fff9, "t1_next");

        // 2: flush to 0000:0100 during a pending fetch (aborted word dropped).
        pulse_load(16'h0000, 16'h0100, 1'b0, "t2_load");
        check_bus(1'b1, 19'h7fff9, "t2_held");
        ack_word(16'hdead);
        wait_fetch(19'h00080, "t2_fetch");
        exp_q.push_back(8'haa);
        exp_q.push_back(8'hbb);
        ack_word(16'hbbaa);
        expect_pushes(2, "t2");
        wait_fetch(19'h00081, "t2_next");

        // 3: flush to odd IP in the same cycle as an ack; single high byte.
        pulse_load(16'h0000, 16'h0101, 1'b1, "t3_load");
        wait_fetch(19'h00080, "t3_fetch");
        exp_q.push_back(8'h34);
        ack_word(16'h3412);
        expect_pushes(1, "t3");
        wait_fetch(19'h00081, "t3_next");

        // 4: fifo_full held three cycles in PUSH_HI.
        exp_q.push_back(8'hcc);
        exp_q.push_back(8'hdd);
        ack_word(16'hddcc);
        @(negedge clk);
        check("t4_lo_push", 32'(bus.fifo_wr_en), 32'd1);
        @(posedge clk); #1;
        bus.fifo_full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t4_stall_wr", 32'(bus.fifo_wr_en), 32'd0);
            check("t4_stall_acc", 32'(bus.mem_access), 32'd0);
        end
        @(posedge clk); #1;
        bus.fifo_full = 1'b0;
        @(negedge clk);
        check("t4_hi_push", 32'(bus.fifo_wr_en), 32'd1);
        wait_fetch(19'h00082, "t4_next");

        // 5: two flushes during an un-acked fetch; address held until ack.
        repeat (2) @(negedge clk);
        pulse_load(16'h0000, 16'h0300, 1'b0, "t5_load1");
        check_bus(1'b1, 19'h00082, "t5_held1");
        pulse_load(16'h0000, 16'h0200, 1'b0, "t5_load2");
        check_bus(1'b1, 19'h00082, "t5_held2");
        ack_word(16'hdead);
        wait_fetch(19'h00100, "t5_fetch");
        exp_q.push_back(8'h66);
        exp_q.push_back(8'h55);
        ack_word(16'h5566);
        expect_pushes(2, "t5");
        wait_fetch(19'h00101, "t5_next");

        // 6: ffff:ffff, address and IP wrap.
        pulse_load(16'hffff, 16'hffff, 1'b0, "t6_load");
        check_bus(1'b1, 19'h00101, "t6_held");
        ack_word(16'hdead);
        wait_fetch(19'h07ff7, "t6_fetch");
        exp_q.push_back(8'h99);
        ack_word(16'h9988);
        expect_pushes(1, "t6");
        wait_fetch(19'h7fff8, "t6_next");

        // 7: reset during an aborted fetch wins over load and clears abort.
        pulse_load(16'h1234, 16'h0010, 1'b0, "t7_load");
        @(posedge clk); #1;
        reset           = 1'b1;
        bus.load_new_ip = 1'b1;
        bus.new_cs      = 16'h4321;
        bus.new_ip      = 16'h0040;
        @(negedge clk);
        check("t7_rst_access", 32'(bus.mem_access), 32'd0);
        check("t7_rst_fifo_reset", 32'(bus.fifo_reset), 32'd0);
        @(posedge clk); #1;
        bus.load_new_ip = 1'b0;
        reset           = 1'b0;
        check_bus(1'b0, 19'h0, "t7_idle");
        check_bus(1'b1, 19'h7fff8, "t7_fetch");
        exp_q.push_back(8'h66);
        exp_q.push_back(8'h77);
        ack_word(16'h7766);
        expect_pushes(2, "t7");

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
